// File: rtl/game_pkg.sv
// Shared encodings for the maze game: top-level state, menu, difficulty,
// in-game substate, move FSM state and the SCENs direction indices.
package game_pkg;

  localparam int MAP_WIDTH_DEF  = 30;
  localparam int MAP_HEIGHT_DEF = 21;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [3:0] {
    GS_MENU    = 4'b0001,
    GS_IN_GAME = 4'b0010,
    GS_LOST    = 4'b0100,
    GS_WON     = 4'b1000
  } game_state_e;

  typedef enum logic [2:0] {
    MS_START = 3'b001,
    MS_DIFF  = 3'b010,
    MS_INSTR = 3'b100
  } menu_sel_e;

  typedef enum logic [2:0] {
    DF_EASY   = 3'b001,
    DF_MEDIUM = 3'b010,
    DF_HARD   = 3'b100
  } difficulty_e;

  typedef enum logic [1:0] {
    SUB_SHOW_MAP = 2'b01,
    SUB_PLAYING  = 2'b10
  } substate_e;

  typedef enum logic [2:0] {
    MV_IDLE  = 3'b001,
    MV_WAIT  = 3'b010,
    MV_CHECK = 3'b100
  } move_state_e;

  // One-hot rotations: forward walks 001->010->100->001.
  function automatic logic [2:0] rot_fwd3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  function automatic logic [2:0] rot_back3(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of the controller's player-input, map-ROM and status signals.
// master = the surrounding system (buttons, ROM), slave = game_ctrl.
interface game_ctrl_if import game_pkg::*; #(
  parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT = MAP_HEIGHT_DEF
);
  logic [3:0]                  SCENs;
  logic                        sel;
  logic [MAP_WIDTH-1:0]        map_data;
  logic [$clog2(MAP_HEIGHT)-1:0] map_addr;
  logic [3:0]                  game_state;
  logic [2:0]                  menu_sel;
  logic [2:0]                  difficulty;
  logic                        map_visible;
  logic [7:0]                  player_x_pos;
  logic [7:0]                  player_y_pos;
  logic                        lost;
  logic                        won;
  logic                        move_busy;

  modport master (
    output SCENs, sel, map_data,
    input  map_addr, game_state, menu_sel, difficulty, map_visible,
           player_x_pos, player_y_pos, lost, won, move_busy
  );

  modport slave (
    input  SCENs, sel, map_data,
    output map_addr, game_state, menu_sel, difficulty, map_visible,
           player_x_pos, player_y_pos, lost, won, move_busy
  );
endinterface

// File: rtl/game_ctrl_move_checker.sv
// Move FSM: picks one direction, queries the map ROM row of the target cell,
// and either commits the new position or flags a wall hit two cycles later.
module move_checker import game_pkg::*; #(
  parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT = MAP_HEIGHT_DEF,
  parameter int START_X    = 0,
  parameter int START_Y    = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_i,
  input  logic                          restart_i,
  input  logic [3:0]                    scens_i,
  input  logic [MAP_WIDTH-1:0]          map_data_i,
  output logic [$clog2(MAP_HEIGHT)-1:0] map_addr_o,
  output logic                          move_busy_o,
  output logic [7:0]                    player_x_o,
  output logic [7:0]                    player_y_o,
  output logic                          hit_wall_o,
  output logic                          at_exit_o
);
  localparam int          AW    = $clog2(MAP_HEIGHT);
  localparam int          XW    = $clog2(MAP_WIDTH);
  localparam logic [7:0]  X_MAX = 8'(MAP_WIDTH - 1);
  localparam logic [7:0]  Y_MAX = 8'(MAP_HEIGHT - 1);

  move_state_e   state_q, state_d;
  logic [7:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [7:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic [7:0]    cand_x_s, cand_y_s;
  logic          cand_ok_s;
  logic          wall_s;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MV_IDLE;
      tgt_x_q <= 8'd0;
      tgt_y_q <= 8'd0;
      pos_x_q <= 8'(START_X);
      pos_y_q <= 8'(START_Y);
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  // Target cell of the highest-priority requested direction; off-map is not ok.
  always_comb begin
    cand_x_s  = pos_x_q;
    cand_y_s  = pos_y_q;
    cand_ok_s = 1'b0;
    if (scens_i[DIR_UP]) begin
      cand_y_s  = pos_y_q - 8'd1;
      cand_ok_s = (pos_y_q != 8'd0);
    end else if (scens_i[DIR_DOWN]) begin
      cand_y_s  = pos_y_q + 8'd1;
      cand_ok_s = (pos_y_q < Y_MAX);
    end else if (scens_i[DIR_LEFT]) begin
      cand_x_s  = pos_x_q - 8'd1;
      cand_ok_s = (pos_x_q != 8'd0);
    end else if (scens_i[DIR_RIGHT]) begin
      cand_x_s  = pos_x_q + 8'd1;
      cand_ok_s = (pos_x_q < X_MAX);
    end else begin
      cand_ok_s = 1'b0;
    end
  end

  assign wall_s = map_data_i[tgt_x_q[XW-1:0]];

  // Move FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MV_IDLE: begin
        if (enable_i && cand_ok_s) state_d = MV_WAIT;
        else                       state_d = MV_IDLE;
      end
      MV_WAIT:  state_d = MV_CHECK;
      MV_CHECK: state_d = MV_IDLE;
      default:  state_d = MV_IDLE;
    endcase
  end

  // Move FSM outputs: latch target and ROM address, commit on an open cell.
  always_comb begin
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    case (state_q)
      MV_IDLE: begin
        if (enable_i && cand_ok_s) begin
          tgt_x_d = cand_x_s;
          tgt_y_d = cand_y_s;
          addr_d  = cand_y_s[AW-1:0];
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      MV_WAIT: busy_d = 1'b1;
      MV_CHECK: begin
        busy_d = 1'b0;
        if (!wall_s) begin
          pos_x_d = tgt_x_q;
          pos_y_d = tgt_y_q;
        end else begin
          pos_x_d = pos_x_q;
        end
      end
      default: busy_d = 1'b0;
    endcase
    if (restart_i) begin
      pos_x_d = 8'(START_X);
      pos_y_d = 8'(START_Y);
    end else begin
      busy_d = busy_d;
    end
  end

  assign hit_wall_o  = (state_q == MV_CHECK) && wall_s;
  assign at_exit_o   = (state_q == MV_CHECK) && !wall_s && (tgt_x_q == X_MAX);
  assign map_addr_o  = addr_q;
  assign move_busy_o = busy_q;
  assign player_x_o  = pos_x_q;
  assign player_y_o  = pos_y_q;

endmodule

// File: rtl/game_ctrl.sv
// Top-level maze game sequencer: menu, difficulty, show-map countdown and
// lost/won handling around the move_checker.
module game_ctrl import game_pkg::*; #(
  parameter int MAP_WIDTH   = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT  = MAP_HEIGHT_DEF,
  parameter int START_X     = 0,
  parameter int START_Y     = 11,
  parameter int SHOW_EASY   = 3000000,
  parameter int SHOW_MEDIUM = 1500000,
  parameter int SHOW_HARD   = 500000
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);
  localparam logic [31:0] LEN_EASY   = 32'(SHOW_EASY - 1);
  localparam logic [31:0] LEN_MEDIUM = 32'(SHOW_MEDIUM - 1);
  localparam logic [31:0] LEN_HARD   = 32'(SHOW_HARD - 1);

  game_state_e gs_q, gs_d;
  substate_e   sub_q, sub_d;
  menu_sel_e   menu_q, menu_d;
  difficulty_e diff_q, diff_d;
  logic        vis_q, vis_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] show_len_s;
  logic        enable_s, restart_s, hit_wall_s, at_exit_s;

  assign enable_s  = (gs_q == GS_IN_GAME) && (sub_q == SUB_PLAYING);
  assign restart_s = bus.sel && ((gs_q == GS_LOST) || (gs_q == GS_WON));

  // Show-map countdown is loaded with length-1 so it ends on the zero cycle.
  always_comb begin
    case (diff_q)
      DF_EASY:   show_len_s = LEN_EASY;
      DF_MEDIUM: show_len_s = LEN_MEDIUM;
      DF_HARD:   show_len_s = LEN_HARD;
      default:   show_len_s = LEN_EASY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      gs_q   <= GS_MENU;
      sub_q  <= SUB_SHOW_MAP;
      menu_q <= MS_START;
      diff_q <= DF_EASY;
      vis_q  <= 1'b0;
      cnt_q  <= 32'd0;
    end else begin
      gs_q   <= gs_d;
      sub_q  <= sub_d;
      menu_q <= menu_d;
      diff_q <= diff_d;
      vis_q  <= vis_d;
      cnt_q  <= cnt_d;
    end
  end

  // Game state and in-game substate next state.
  always_comb begin
    gs_d  = gs_q;
    sub_d = sub_q;
    case (gs_q)
      GS_MENU: begin
        if (bus.sel && (menu_q == MS_START)) begin
          gs_d  = GS_IN_GAME;
          sub_d = SUB_SHOW_MAP;
        end else begin
          gs_d  = GS_MENU;
        end
      end
      GS_IN_GAME: begin
        if (sub_q == SUB_SHOW_MAP) begin
          if (cnt_q == 32'd0) sub_d = SUB_PLAYING;
          else                sub_d = SUB_SHOW_MAP;
        end else if (hit_wall_s) begin
          gs_d = GS_LOST;
        end else if (at_exit_s) begin
          gs_d = GS_WON;
        end else begin
          gs_d = GS_IN_GAME;
        end
      end
      GS_LOST, GS_WON: begin
        if (bus.sel) gs_d = GS_MENU;
        else         gs_d = gs_q;
      end
      default: gs_d = GS_MENU;
    endcase
  end

  // Menu, difficulty, map visibility and countdown updates.
  always_comb begin
    menu_d = menu_q;
    diff_d = diff_q;
    vis_d  = vis_q;
    cnt_d  = cnt_q;
    case (gs_q)
      GS_MENU: begin
        if (bus.SCENs[DIR_UP])        menu_d = menu_sel_e'(rot_back3(menu_q));
        else if (bus.SCENs[DIR_DOWN]) menu_d = menu_sel_e'(rot_fwd3(menu_q));
        else                          menu_d = menu_q;
        if (bus.sel && (menu_q == MS_START)) begin
          vis_d = 1'b1;
          cnt_d = show_len_s;
        end else if (bus.sel && (menu_q == MS_DIFF)) begin
          diff_d = difficulty_e'(rot_fwd3(diff_q));
        end else begin
          diff_d = diff_q;
        end
      end
      GS_IN_GAME: begin
        if (sub_q != SUB_SHOW_MAP) vis_d = 1'b0;
        else if (cnt_q == 32'd0)   vis_d = 1'b0;
        else                       cnt_d = cnt_q - 32'd1;
      end
      GS_LOST, GS_WON: begin
        if (bus.sel) vis_d = 1'b0;
        else         vis_d = vis_q;
      end
      default: vis_d = 1'b0;
    endcase
  end

  move_checker #(
    .MAP_WIDTH (MAP_WIDTH),
    .MAP_HEIGHT(MAP_HEIGHT),
    .START_X   (START_X),
    .START_Y   (START_Y)
  ) u_move (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable_s),
    .restart_i  (restart_s),
    .scens_i    (bus.SCENs),
    .map_data_i (bus.map_data),
    .map_addr_o (bus.map_addr),
    .move_busy_o(bus.move_busy),
    .player_x_o (bus.player_x_pos),
    .player_y_o (bus.player_y_pos),
    .hit_wall_o (hit_wall_s),
    .at_exit_o  (at_exit_s)
  );

  assign bus.game_state  = gs_q;
  assign bus.menu_sel    = menu_q;
  assign bus.difficulty  = diff_q;
  assign bus.map_visible = vis_q;
  assign bus.lost        = gs_q[2];
  assign bus.won         = gs_q[3];

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: menu vector table, directed move/countdown sequences,
// then random stimulus against a rule-level reference model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int W = 30, H = 21, SX = 0, SY = 11;
  localparam int SE = 8, SM = 5, SH = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_ctrl_if #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) bus ();

  game_ctrl #(
    .MAP_WIDTH(W), .MAP_HEIGHT(H), .START_X(SX), .START_Y(SY),
    .SHOW_EASY(SE), .SHOW_MEDIUM(SM), .SHOW_HARD(SH)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [W-1:0] rom [0:31];
  always @(posedge clk) bus.map_data <= rom[bus.map_addr];

  int n_chk = 0, n_fail = 0;

  // Reference model: state 0 menu, 1 in game, 2 lost, 3 won; menu/diff as 0..2.
  int m_state, m_menu, m_diff, m_show, m_busy, m_x, m_y, m_tx, m_ty, m_addr;
  int dur [3] = '{SE, SM, SH};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_menu = 0; m_diff = 0; m_show = 0; m_busy = 0;
    m_x = SX; m_y = SY; m_tx = 0; m_ty = 0; m_addr = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic se, input logic r);
    int om, nx, ny;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        om = m_menu;
        if (s[0])      m_menu = (m_menu + 2) % 3;
        else if (s[1]) m_menu = (m_menu + 1) % 3;
        if (se && om == 0) begin
          m_state = 1;
          m_show  = dur[m_diff];
        end else if (se && om == 1) begin
          m_diff = (m_diff + 1) % 3;
        end
      end
      1: begin
        if (m_show > 0) begin
          m_show--;
        end else if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            if (rom[m_ty][m_tx]) m_state = 2;
            else begin
              m_x = m_tx; m_y = m_ty;
              if (m_x == W - 1) m_state = 3;
            end
          end
        end else if (s != 4'b0000) begin
          nx = m_x; ny = m_y;
          if (s[0])      ny = m_y - 1;
          else if (s[1]) ny = m_y + 1;
          else if (s[2]) nx = m_x - 1;
          else           nx = m_x + 1;
          if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
            m_tx = nx; m_ty = ny; m_busy = 2; m_addr = ny;
          end
        end
      end
      default: begin
        if (se) begin
          m_state = 0; m_x = SX; m_y = SY;
        end
      end
    endcase
  endtask

  function automatic logic [34:0] model_vec();
    return {4'(1 << m_state), 3'(1 << m_menu), 3'(1 << m_diff),
            (m_state == 1 && m_show > 0), 8'(m_x), 8'(m_y),
            (m_state == 2), (m_state == 3), (m_busy > 0), 5'(m_addr)};
  endfunction

  function automatic logic [34:0] dut_vec();
    return {bus.game_state, bus.menu_sel, bus.difficulty, bus.map_visible,
            bus.player_x_pos, bus.player_y_pos, bus.lost, bus.won,
            bus.move_busy, bus.map_addr};
  endfunction

  // One clock: drive inputs, advance model at the edge, compare on negedge.
  task automatic tick(input logic [3:0] s, input logic se, input logic r);
    bus.SCENs = s; bus.sel = se; reset = r;
    @(posedge clk);
    model_step(s, se, r);
    @(negedge clk);
    chk("model", 64'(dut_vec()), 64'(model_vec()));
  endtask

  typedef struct {
    logic [3:0] scens;
    logic       sel;
    logic [2:0] exp_menu;
    logic [2:0] exp_diff;
  } menu_vec_t;

  menu_vec_t mtab [11];
  int vis_cnt;

  initial begin
    bus.SCENs = 4'b0000; bus.sel = 1'b0; bus.map_data = '0; reset = 1'b1;
    for (int r = 0; r < 32; r++) rom[r] = '0;
    model_reset();

    // Reset state
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0);
    chk("rst_state", 64'(bus.game_state), 64'(4'b0001));
    chk("rst_menu_diff", 64'({bus.menu_sel, bus.difficulty}), 64'({3'b001, 3'b001}));
    chk("rst_pos", 64'({bus.player_x_pos, bus.player_y_pos}), 64'({8'd0, 8'd11}));
    chk("rst_misc", 64'({bus.map_visible, bus.move_busy, bus.map_addr}), 64'(7'd0));

    // Menu navigation table
    mtab[0]  = '{4'b0010, 1'b0, 3'b010, 3'b001};
    mtab[1]  = '{4'b0010, 1'b0, 3'b100, 3'b001};
    mtab[2]  = '{4'b0010, 1'b0, 3'b001, 3'b001};
    mtab[3]  = '{4'b0001, 1'b0, 3'b100, 3'b001};
    mtab[4]  = '{4'b0001, 1'b0, 3'b010, 3'b001};
    mtab[5]  = '{4'b0000, 1'b1, 3'b010, 3'b010};
    mtab[6]  = '{4'b0000, 1'b1, 3'b010, 3'b100};
    mtab[7]  = '{4'b0000, 1'b1, 3'b010, 3'b001};
    mtab[8]  = '{4'b0100, 1'b0, 3'b010, 3'b001};
    mtab[9]  = '{4'b1000, 1'b0, 3'b010, 3'b001};
    mtab[10] = '{4'b0001, 1'b0, 3'b001, 3'b001};
    for (int i = 0; i < 11; i++) begin
      tick(mtab[i].scens, mtab[i].sel, 1'b0);
      chk("menu_tbl", 64'({bus.game_state, bus.menu_sel, bus.difficulty}),
          64'({4'b0001, mtab[i].exp_menu, mtab[i].exp_diff}));
    end

    // Start: map shown for exactly SHOW_EASY cycles, right pulse ignored
    tick(4'b0000, 1'b1, 1'b0);
    chk("start_state", 64'(bus.game_state), 64'(4'b0010));
    vis_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.map_visible) break;
      vis_cnt++;
      tick((i == 2) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
    end
    chk("show_len", 64'(vis_cnt), 64'(SE));
    chk("show_pos", 64'({bus.player_x_pos, bus.player_y_pos}), 64'({8'd0, 8'd11}));

    // Open move right, second pulse while busy is dropped
    tick(4'b1000, 1'b0, 1'b0);
    chk("mv_busy_n", 64'({bus.move_busy, bus.map_addr}), 64'({1'b1, 5'd11}));
    tick(4'b1000, 1'b0, 1'b0);
    chk("mv_busy_n1", 64'({bus.move_busy, bus.player_x_pos}), 64'({1'b1, 8'd0}));
    tick(4'b0000, 1'b0, 1'b0);
    chk("mv_commit", 64'({bus.move_busy, bus.player_x_pos}), 64'({1'b0, 8'd1}));
    repeat (3) tick(4'b0000, 1'b0, 1'b0);
    chk("mv_dropped", 64'(bus.player_x_pos), 64'(8'd1));

    // Up beats right; then back down and left to the start cell
    tick(4'b0101, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
    chk("prio_up", 64'({bus.player_x_pos, bus.player_y_pos}), 64'({8'd1, 8'd10}));
    tick(4'b0010, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
    chk("back_home", 64'({bus.player_x_pos, bus.player_y_pos}), 64'({8'd0, 8'd11}));
    tick(4'b0100, 1'b0, 1'b0);
    chk("left_edge", 64'({bus.move_busy, bus.map_addr}), 64'({1'b0, 5'd11}));

    // Wall at (1,11): lost after two cycles, position kept, sel back to menu
    rom[11][1] = 1'b1;
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    chk("lost_n1", 64'(bus.game_state), 64'(4'b0010));
    tick(4'b0000, 1'b0, 1'b0);
    chk("lost", 64'({bus.game_state, bus.lost, bus.player_x_pos}), 64'({4'b0100, 1'b1, 8'd0}));
    repeat (3) tick(4'b1000, 1'b0, 1'b0);
    chk("lost_frozen", 64'({bus.move_busy, bus.player_x_pos}), 64'({1'b0, 8'd0}));
    tick(4'b0000, 1'b1, 1'b0);
    chk("lost_to_menu", 64'({bus.game_state, bus.map_visible, bus.player_x_pos, bus.player_y_pos}),
        64'({4'b0001, 1'b0, 8'd0, 8'd11}));
    rom[11][1] = 1'b0;

    // Walk right to the last column on an open row
    tick(4'b0000, 1'b1, 1'b0);
    repeat (SE) tick(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < W - 1; k++) begin
      tick(4'b1000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
    end
    chk("won", 64'({bus.game_state, bus.won, bus.lost, bus.player_x_pos}),
        64'({4'b1000, 1'b1, 1'b0, 8'd29}));
    tick(4'b0000, 1'b1, 1'b0);

    // Reset on the WAIT edge of a query, and mid-countdown
    tick(4'b0000, 1'b1, 1'b0);
    repeat (SE) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b1);
    chk("rst_wait", 64'({bus.game_state, bus.move_busy, bus.player_x_pos, bus.player_y_pos, bus.map_addr}),
        64'({4'b0001, 1'b0, 8'd0, 8'd11, 5'd0}));
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b1);
    chk("rst_show", 64'({bus.game_state, bus.map_visible}), 64'({4'b0001, 1'b0}));

    // Random play on a random maze
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) rom[r][c] = ($urandom_range(0, 5) == 0);
    rom[SY][SX] = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'b0000,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequencing controller for the maze game. It owns the top-level game state (menu, in game, lost, won) and the difficulty and menu selections. It also runs the show-map countdown and holds the player position. Every move request is checked against the map ROM with a fixed two-cycle query before it commits. The pixel renderer consumes its outputs read-only; the controller drives the map ROM address port whenever a move query is in flight.

## Interface
Parameters:
- MAP_WIDTH, 30, map columns; ROM word width.
- MAP_HEIGHT, 21, map rows; ROM depth.
- START_X, 0, player column after reset or restart.
- START_Y, 11, player row after reset or restart.
- SHOW_EASY, 3000000, show-map duration in clk cycles at easy difficulty.
- SHOW_MEDIUM, 1500000, show-map duration at medium difficulty.
- SHOW_HARD, 500000, show-map duration at hard difficulty.

Ports:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- SCENs, in, 4, single-cycle move pulses: [0] up, [1] down, [2] left, [3] right.
- sel, in, 1, single-cycle select/confirm pulse.
- map_data, in, MAP_WIDTH, ROM row data; bit [x] = 1 means wall. Valid one cycle after map_addr is sampled.
- map_addr, out, $clog2(MAP_HEIGHT), registered ROM row address.
- game_state, out, 4, one-hot: 0001 menu, 0010 in_game, 0100 lost, 1000 won.
- menu_sel, out, 3, one-hot: 001 start, 010 difficulty, 100 instructions.
- difficulty, out, 3, one-hot: 001 easy, 010 medium, 100 hard.
- map_visible, out, 1, high during the show-map phase.
- player_x_pos, out, 8, player column.
- player_y_pos, out, 8, player row.
- lost, out, 1, equals game_state[2].
- won, out, 1, equals game_state[3].
- move_busy, out, 1, high while a move query is in flight.

## Operation
- Reset values:
  - game_state=0001, menu_sel=001, difficulty=001.
  - map_visible=0, player=(START_X, START_Y), map_addr=0, move_busy=0.
  - Show-map counter=0; move FSM in IDLE.
- Menu state:
  - SCENs[0] rotates menu_sel backwards (start→instructions); SCENs[1] rotates forwards.
  - sel with menu_sel=start: go to in_game, set map_visible=1, load the counter with SHOW_x-1 for the current difficulty.
  - sel with menu_sel=difficulty: rotate difficulty easy→medium→hard→easy.
  - sel with menu_sel=instructions: no effect.
  - Left/right pulses are ignored in the menu.
- In-game substates:
  - SHOW_MAP: map_visible=1; the counter decrements each cycle. At counter==0 the next edge moves to PLAYING with map_visible=0. Moves and sel are ignored.
  - PLAYING: runs the move FSM. sel is ignored.
- Move FSM: IDLE → WAIT → CHECK → IDLE.
  - IDLE, on any SCENs bit: pick one direction; priority up>down>left>right.
  - Compute the target cell. If it is outside [0, MAP_WIDTH-1]×[0, MAP_HEIGHT-1], drop the request and stay in IDLE.
  - Otherwise latch the target, set map_addr=target_y, move_busy=1, go to WAIT.
  - WAIT: one cycle for the ROM read.
  - CHECK: sample map_data[target_x].
    - Bit=1: game_state=lost; position unchanged.
    - Bit=0: commit target to player_x_pos/player_y_pos. If target_x==MAP_WIDTH-1, game_state=won.
    - Return to IDLE with move_busy=0.
  - SCENs pulses arriving while move_busy=1 are dropped, not queued.
- Lost/won state: sel returns to the menu. It restores the player to (START_X, START_Y) and clears map_visible; menu_sel and difficulty are kept. SCENs are ignored.
- reset at any time, including mid-query or mid-countdown, restores all reset values on that edge. It overrides every other event in the same cycle.

## Timing
- Move accepted at edge N: map_addr valid after N.
- ROM registers data at edge N+1.
- Position, lost or won update at edge N+2, so move latency is 2 cycles.
- Next move is accepted at N+3 at the earliest.
- Show-map phase lasts exactly SHOW_x cycles with map_visible=1, counted from the edge that sampled sel.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Structure
- Shared package game_pkg holds:
  - the one-hot encodings for game_state, menu_sel, difficulty and in-game substate;
  - the direction indices of SCENs;
  - MAP_WIDTH/MAP_HEIGHT defaults.
- The renderer imports the same package.
- One sub-module, move_checker, contains the move FSM, target computation, ROM handshake and position registers. game_ctrl instantiates it and gates it with PLAYING.

## Test plan
- Reset, then sel at menu_sel=start with SHOW_EASY=8 → game_state=0010 and map_visible=1 for exactly 8 cycles, then 0. SCENs[3] pulsed during that window leaves player=(0,11).
- Menu: SCENs[1]×2 → menu_sel=100. SCENs[1] again → 001. SCENs[0] → 100. With menu_sel=010, sel×3 → difficulty 010, 100, 001.
- PLAYING, map row 11 bit1=0: SCENs[3] at edge N → move_busy=1 at N..N+1, player_x_pos=1 at N+2. A second SCENs[3] at N+1 is dropped.
- PLAYING at (0,11) with row 11 bit1=1: SCENs[3] → game_state=0100 and lost=1 at N+2, player unchanged. sel → menu, player=(0,11).
- Boundaries: at (0,11), SCENs[2] → no query, map_addr unchanged. SCENs=0101 → up wins, player_y_pos=10. Reaching x=29 on an open cell → won=1.
- reset asserted at the WAIT edge → next cycle game_state=0001, move_busy=0, player=(0,11).
